// File: rtl/rec_fn_to_fn_pipe_pkg.sv
// Shared definitions for the recoded-to-IEEE binary64 conversion pipeline.
//   EXP_WIDTH / SIG_WIDTH / REC_WIDTH : fixed double-precision geometry
//   MIN_NORM_EXP                      : smallest recoded exponent that packs as a normal
//   EXP_BIAS_ADJ                      : recoded exponent minus this gives the IEEE exponent
//   rawFloat_t                        : unpacked classification + raw exponent/significand
package rec_fn_to_fn_pipe_pkg;

    localparam int EXP_WIDTH    = 11;
    localparam int SIG_WIDTH    = 53;
    localparam int REC_WIDTH    = 65;
    localparam int MIN_NORM_EXP = 1026;
    localparam int EXP_BIAS_ADJ = 1025;

    typedef struct packed {
        logic        isNaN;
        logic        isInf;
        logic        isZero;
        logic        isSNaN;
        logic        sign;
        logic [12:0] sExp;
        logic [55:0] sig;
    } rawFloat_t;

endpackage

// File: rtl/rec_fn_classify.sv
// Combinational classifier: splits a recoded binary64 word into raw form.
//   recIn : recoded float, [64] sign, [63:52] recExp, [51:0] fract
//   raw   : classification flags plus raw signed exponent and significand
module rec_fn_classify
    import rec_fn_to_fn_pipe_pkg::*;
(
    input  logic [REC_WIDTH-1:0] recIn,
    output rawFloat_t            raw
);

    logic [11:0] recExp;
    logic [51:0] fract;
    logic        isSpecial;

    assign recExp    = recIn[63:52];
    assign fract     = recIn[51:0];
    // Top two exponent bits both set marks Inf/NaN; bit 9 separates them.
    assign isSpecial = (recExp[11:10] == 2'b11);

    always_comb begin
        raw        = '0;
        raw.isZero = (recExp[11:9] == 3'b000);
        raw.isNaN  = isSpecial & recExp[9];
        raw.isInf  = isSpecial & ~recExp[9];
        // Signalling NaN: quiet bit (fract MSB) clear.
        raw.isSNaN = raw.isNaN & ~fract[51];
        raw.sign   = recIn[64];
        raw.sExp   = {1'b0, recExp};
        raw.sig    = {1'b0, ~raw.isZero, fract, 2'b00};
    end

endmodule

// File: rtl/rec_fn_to_fn_pipe.sv
// Two-stage valid/ready pipeline converting recoded binary64 to IEEE binary64.
//   clock, reset                : sole clock, synchronous active-high reset
//   io_flush                    : discards all words in flight at the next edge
//   io_in_valid/ready/bits      : recoded input handshake (65-bit word)
//   io_out_valid/ready          : result handshake
//   io_out_ieee                 : packed IEEE binary64
//   io_out_is*/sign/sExp/sig    : raw-form classification of the same word
// S1 holds the classified input; IEEE packing happens between S1 and S2.
module rec_fn_to_fn_pipe
    import rec_fn_to_fn_pipe_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_flush,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [REC_WIDTH-1:0] io_in_bits,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [63:0]          io_out_ieee,
    output logic                 io_out_isNaN,
    output logic                 io_out_isInf,
    output logic                 io_out_isZero,
    output logic                 io_out_sign,
    output logic                 io_out_isSNaN,
    output logic [12:0]          io_out_sExp,
    output logic [55:0]          io_out_sig
);

    rawFloat_t   inRaw;
    rawFloat_t   s1Raw, s2Raw;
    logic        s1Valid, s2Valid;
    logic [63:0] s2Ieee;

    logic        s1Adv, s2Adv, inFire;

    rec_fn_classify uClassify (
        .recIn (io_in_bits),
        .raw   (inRaw)
    );

    // ---------------- handshake control ----------------
    assign s2Adv       = ~s2Valid | io_out_ready;
    assign s1Adv       = ~s1Valid | s2Adv;
    assign io_in_ready = s1Adv & ~io_flush & ~reset;
    assign inFire      = io_in_valid & io_in_ready;

    // ---------------- IEEE packing (S1 -> S2) ----------------
    // s1Raw carries every input bit: sign, recExp in sExp[11:0], fract in sig[53:2].
    logic [10:0] recExpLo;
    logic [51:0] fract;
    logic        isSubnormal;
    logic [5:0]  shift;
    logic [51:0] denormSrc;
    logic [51:0] denormFract;
    logic [10:0] expOut;
    logic [51:0] fracOut;
    logic [63:0] packedIeee;

    assign recExpLo    = s1Raw.sExp[10:0];
    assign fract       = s1Raw.sig[53:2];
    assign isSubnormal = (s1Raw.sExp < 13'(MIN_NORM_EXP));
    // Only the low 6 exponent bits matter: valid subnormals span a 52-wide window,
    // so (1 - sExp) wraps into the 0..51 right-shift range.
    assign shift       = 6'd1 - s1Raw.sExp[5:0];
    // Hidden one sits at the top; fract[0] always shifts out for subnormals.
    assign denormSrc   = {~s1Raw.isZero, fract[51:1]};
    assign denormFract = denormSrc >> shift;

    always_comb begin
        expOut = isSubnormal ? 11'd0 : (recExpLo - 11'(EXP_BIAS_ADJ));
        if (s1Raw.isNaN | s1Raw.isInf)
            expOut = expOut | 11'h7FF;

        if (isSubnormal)
            fracOut = denormFract;
        else if (s1Raw.isInf)
            fracOut = '0;
        else
            fracOut = fract;    // NaN payload passes through untouched

        packedIeee = {s1Raw.sign, expOut, fracOut};
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            s1Raw   <= '0;
            s2Raw   <= '0;
            s2Ieee  <= '0;
        end else begin
            if (io_flush) begin
                s1Valid <= 1'b0;
                s2Valid <= 1'b0;
            end else begin
                if (s1Adv) s1Valid <= inFire;
                if (s2Adv) s2Valid <= s1Valid;
            end

            // inFire already excludes flush.
            if (inFire)
                s1Raw <= inRaw;

            // Load S2 data only when a real word moves in, so a drained S2
            // keeps its last value and a stalled S2 is held stable.
            if (s2Adv && s1Valid && !io_flush) begin
                s2Raw  <= s1Raw;
                s2Ieee <= packedIeee;
            end
        end
    end

    // ---------------- outputs ----------------
    // Reset and flush both suppress the output handshake in the same cycle,
    // so a discarded word is never seen as transferred.
    assign io_out_valid  = s2Valid & ~io_flush & ~reset;
    assign io_out_ieee   = reset ? 64'd0 : s2Ieee;
    assign io_out_isNaN  = ~reset & s2Raw.isNaN;
    assign io_out_isInf  = ~reset & s2Raw.isInf;
    assign io_out_isZero = ~reset & s2Raw.isZero;
    assign io_out_sign   = ~reset & s2Raw.sign;
    assign io_out_isSNaN = ~reset & s2Raw.isSNaN;
    assign io_out_sExp   = reset ? 13'd0 : s2Raw.sExp;
    assign io_out_sig    = reset ? 56'd0 : s2Raw.sig;

endmodule
